ask2_demod: RTL

- Non-coherent 2ASK receiver. It is the receive-side counterpart of the NCO carrier generator and on/off keyer in the 2ASK chain.
- Takes a stream of Q1.15 signed samples of an on/off-keyed carrier. It full-wave rectifies each sample and integrates-and-dumps over one bit period, then slices the sum against a threshold.
- Emits one recovered bit per bit period. Bit timing is acquired from carrier onset; lock is dropped after a run of zero bits.

---
 rtl/ask2_pkg.sv | 19 +
 rtl/ask2_demod_if.sv | 14 +
 rtl/ask2_int_dump.sv | 60 ++++++
 rtl/ask2_demod.sv | 91 +++++++++
 4 files changed

// File: rtl/ask2_pkg.sv
// Shared types and Q1.15 helpers for the 2ASK receive path.
package ask2_pkg;

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 32;

  localparam logic [SAMPLE_W-1:0] Q15_MAX = 16'h7FFF;
  localparam logic [SAMPLE_W-1:0] Q15_MIN = 16'h8000;

  // Full-wave rectify; the most negative code has no positive twin and clips.
  function automatic logic [SAMPLE_W-1:0] q15_abs(input logic [SAMPLE_W-1:0] x);
    if (x == Q15_MIN) return Q15_MAX;
    else if (x[SAMPLE_W-1]) return -x;
    else return x;
  endfunction

endpackage

// File: rtl/ask2_demod_if.sv
// Sample stream in, recovered bit stream out, for the 2ASK demodulator.
interface ask2_demod_if;

  logic                           in_valid;
  logic [ask2_pkg::SAMPLE_W-1:0]  in_data;
  logic                           bit_out;
  logic                           bit_valid;
  logic [ask2_pkg::ACC_W-1:0]     energy;
  logic                           locked;

  modport master (output in_valid, in_data, input bit_out, bit_valid, energy, locked);
  modport slave  (input in_valid, in_data, output bit_out, bit_valid, energy, locked);

endinterface

// File: rtl/ask2_int_dump.sv
// Integrate-and-dump over one bit window, slices the sum against THRESH.
// Latency: decision registered one edge after the window's last enabled sample; no backpressure.
module ask2_int_dump
  import ask2_pkg::*;
#(
  parameter int               SAMPLES_PER_BIT = 500,
  parameter logic [ACC_W-1:0] THRESH          = 32'd5_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                clear,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] abs_val,
  output logic                dump_next,
  output logic                bit_next,
  output logic                dump,
  output logic                bit_dec,
  output logic [ACC_W-1:0]    energy
);

  localparam logic [15:0] LAST = 16'(SAMPLES_PER_BIT - 1);

  logic [15:0]      cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  always_comb begin
    sum       = acc + ACC_W'(abs_val);
    dump_next = en && !clear && (cnt == LAST);
    bit_next  = (sum >= THRESH);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt     <= '0;
      acc     <= '0;
      dump    <= 1'b0;
      bit_dec <= 1'b0;
      energy  <= '0;
    end else begin
      dump <= 1'b0;
      if (clear) begin
        cnt <= '0;
        acc <= '0;
      end else if (en) begin
        if (cnt == LAST) begin
          energy  <= sum;
          bit_dec <= bit_next;
          dump    <= 1'b1;
          cnt     <= '0;
          acc     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ask2_demod.sv
// Non-coherent 2ASK receiver: rectify, integrate-and-dump, slice; timing acquired on carrier onset.
// Latency: bit_valid on the 2nd edge after the last sample of a bit; no backpressure, in_valid gaps stretch the window.
module ask2_demod
  import ask2_pkg::*;
#(
  parameter int                  SAMPLES_PER_BIT = 500,
  parameter logic [ACC_W-1:0]    THRESH          = 32'd5_000_000,
  parameter logic [SAMPLE_W-1:0] ONSET_LEVEL     = 16'd8192,
  parameter int                  IDLE_BITS       = 16
) (
  input logic         sys_clk,
  input logic         sys_rst,
  ask2_demod_if.slave bus
);

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_BITS - 1);

  state_t              state, state_nxt;
  logic [SAMPLE_W-1:0] abs_r;
  logic                abs_v;
  logic [7:0]          idle_cnt;
  logic                onset, en, clear, locked;
  logic                dump_next, bit_next, dump, bit_dec;
  logic [ACC_W-1:0]    energy;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      abs_r <= '0;
      abs_v <= 1'b0;
    end else begin
      abs_r <= q15_abs(bus.in_data);
      abs_v <= bus.in_valid;
    end
  end

  assign onset = abs_v && (abs_r >= ONSET_LEVEL);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= HUNT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (onset) state_nxt = TRACK;
      TRACK:   if (dump_next && !bit_next && idle_cnt == IDLE_LAST) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // The onset sample itself opens the window, so the integrator is enabled on that cycle too.
  always_comb begin
    locked = (state == TRACK);
    clear  = (state == HUNT) && !onset;
    en     = abs_v && ((state == TRACK) || onset);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idle_cnt <= '0;
    end else if (state == HUNT) begin
      idle_cnt <= '0;
    end else if (dump_next) begin
      if (bit_next || idle_cnt == IDLE_LAST) idle_cnt <= '0;
      else                                   idle_cnt <= idle_cnt + 8'd1;
    end
  end

  ask2_int_dump #(
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT),
    .THRESH          (THRESH)
  ) u_int_dump (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .clear     (clear),
    .en        (en),
    .abs_val   (abs_r),
    .dump_next (dump_next),
    .bit_next  (bit_next),
    .dump      (dump),
    .bit_dec   (bit_dec),
    .energy    (energy)
  );

  assign bus.bit_out   = bit_dec;
  assign bus.bit_valid = dump;
  assign bus.energy    = energy;
  assign bus.locked    = locked;

endmodule
